// File: rtl/rf_host_bridge_pkg.sv
// rtl/rf_host_bridge_pkg.sv - shared state and error encodings for the register-file host bridge
package rf_host_bridge_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    localparam logic [1:0] ERR_OK      = 2'b00;
    localparam logic [1:0] ERR_INVALID = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;

endpackage

// File: rtl/rf_host_bridge_timer.sv
// rtl/rf_host_bridge_timer.sv - wait-cycle counter that flags the last permitted WAIT cycle
module rf_host_bridge_timer #(
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic res_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    logic [7:0] count;

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && !expired) begin
            count <= count + 8'd1;
        end
    end

    // Combinational so the bridge can leave WAIT in the very cycle the limit is reached.
    assign expired = (count == 8'(TIMEOUT - 1));

endmodule

// File: rtl/rf_host_bridge.sv
// rtl/rf_host_bridge.sv - command/response master for the register-file access port (timeout under RF_HOST_BRIDGE_TIMEOUT_EN)
module rf_host_bridge
    import rf_host_bridge_pkg::*;
#(
    parameter int ADDR_W  = 3,
    parameter int DATA_W  = 64,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              res_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic [1:0]        rsp_err,
    output logic [ADDR_W-1:0] rf_address,
    output logic              rf_read_en,
    output logic              rf_write_en,
    output logic [DATA_W-1:0] rf_write_data,
    input  logic [DATA_W-1:0] rf_read_data,
    input  logic              rf_invalid_address,
    input  logic              rf_access_complete
);

    state_t state, next_state;
    logic   write_q;
    logic   accept;
    logic   timer_expired;

    assign accept = (state == IDLE) && cmd_valid && cmd_ready;

`ifdef RF_HOST_BRIDGE_TIMEOUT_EN
    rf_host_bridge_timer #(
        .TIMEOUT(TIMEOUT)
    ) u_timer (
        .clk    (clk),
        .res_n  (res_n),
        .clear  (state == ISSUE),
        .enable ((state == WAIT) && !rf_access_complete),
        .expired(timer_expired)
    );
`else
    logic timeout_unused;
    assign timeout_unused = (TIMEOUT != 0);
    assign timer_expired  = 1'b0;
`endif

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (accept) next_state = ISSUE;
            ISSUE:   next_state = WAIT;
            WAIT:    if (rf_access_complete || timer_expired) next_state = RESP;
            RESP:    if (rsp_ready) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            state         <= IDLE;
            cmd_ready     <= 1'b0;
            rsp_valid     <= 1'b0;
            rsp_rdata     <= '0;
            rsp_err       <= ERR_OK;
            rf_read_en    <= 1'b0;
            rf_write_en   <= 1'b0;
            rf_address    <= '0;
            rf_write_data <= '0;
            write_q       <= 1'b0;
        end else begin
            state       <= next_state;
            cmd_ready   <= (next_state == IDLE);
            rsp_valid   <= (next_state == RESP);
            rf_write_en <= accept && cmd_write;
            rf_read_en  <= accept && !cmd_write;
            if (accept) begin
                write_q       <= cmd_write;
                rf_address    <= cmd_addr;
                rf_write_data <= cmd_wdata;
            end
            // Completion outside WAIT (same-cycle as strobe, or after a timeout) is ignored.
            if (state == WAIT) begin
                if (rf_access_complete) begin
                    rsp_err   <= rf_invalid_address ? ERR_INVALID : ERR_OK;
                    rsp_rdata <= (!write_q && !rf_invalid_address) ? rf_read_data : '0;
                end else if (timer_expired) begin
                    rsp_err   <= ERR_TIMEOUT;
                    rsp_rdata <= '0;
                end
            end
        end
    end

endmodule
